pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0, 1 <= STAGES <= WIDTH.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_i  input  1  operand beat valid.
REQ-006 SHALL have port ready_o  output  1  block accepts a beat this cycle.
REQ-007 SHALL have ports a_i, b_i  input  WIDTH  operands.
REQ-008 SHALL have port carry_i  input  1  carry-in, used in add mode.
REQ-009 SHALL have port sub_i  input  1  mode: 0 = a+b+carry_i, 1 = a-b (a + ~b + 1, carry_i ignored).
REQ-010 SHALL have port valid_o  output  1  result beat valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts result.
REQ-012 SHALL have port sum_o  output  WIDTH  result.
REQ-013 SHALL have port carry_o  output  1  carry-out of MSB (in sub mode: 1 = no borrow).
REQ-014 SHALL have port overflow_o  output  1  signed two's-complement overflow flag.

Function
REQ-015 SHALL split operands into STAGES chunks of CW = WIDTH/STAGES bits; stage k adds chunk k with carry from stage k-1's register.
REQ-016 SHALL register per stage: valid bit, completed low sum chunks, pending high operand chunks, mode, inter-stage carry.
REQ-017 SHALL have latency exactly STAGES cycles from accepted beat (valid_i && ready_o) to valid_o, absent stalls.
REQ-018 SHALL sustain throughput of one beat per cycle when ready_i is held 1.
REQ-019 SHALL use global advance enable en = !valid_o || ready_i; ready_o = en; all stage registers hold when en = 0.
REQ-020 SHALL keep sum_o, carry_o, overflow_o, valid_o stable while valid_o && !ready_i.
REQ-021 SHALL propagate bubbles (valid 0 stages) when en = 1; data in bubble stages is don't-care.
REQ-022 SHALL compute results modulo 2^WIDTH; carry_o is bit WIDTH of the full sum.
REQ-023 SHALL give STAGES == 1 as a single registered full-width add, latency 1.

Reset
REQ-024 SHALL clear all stage valid bits asynchronously when rst_ni = 0; valid_o = 0, sum_o = 0, carry_o = 0, overflow_o = 0 during and after reset.
REQ-025 SHALL discard in-flight beats on reset mid-operation; ready_o = 1 on first cycle after release.

Configuration
REQ-026 SHALL, with PIPE_ADDER_OVERFLOW_EN defined, drive overflow_o = (MSB of a == MSB of effective b) && (MSB of sum != MSB of a), pipelined with the result.
REQ-027 SHALL, without PIPE_ADDER_OVERFLOW_EN, tie overflow_o to 0 and implement no overflow logic.

Structure
REQ-028 SHALL place mode encoding (ADD/SUB enum) and a chunk-width helper function in shared package adder_pkg.
REQ-029 SHALL use one sub-module adder_chunk (CW-bit combinational ripple add with carry in/out) instantiated per stage by generate loop.

Verification
REQ-030 SHALL cover: WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=0x1, carry_i=0, sub_i=0 -> after 4 cycles sum_o=0x0, carry_o=1, overflow_o=0.
REQ-031 SHALL cover: a=0x7FFFFFFF, b=0x1, add, macro defined -> sum_o=0x80000000, carry_o=0, overflow_o=1; macro undefined -> overflow_o=0.
REQ-032 SHALL cover: a=0x5, b=0x7, sub_i=1, carry_i=1 -> sum_o=0xFFFFFFFE, carry_o=0 (borrow).
REQ-033 SHALL cover: 8 back-to-back beats a=i, b=i (i=1..8), ready_i=1 -> valid_o high 8 consecutive cycles starting cycle 4, sum_o=2,4,...,16 in order.
REQ-034 SHALL cover: ready_i=0 for 5 cycles while streaming -> ready_o=0 once valid_o=1, sum_o held, no beat lost or duplicated after ready_i=1.
REQ-035 SHALL cover: rst_ni pulsed low with 3 beats in flight -> valid_o=0 immediately, no stale result emerges after release.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation mode encoding and
// chunk sizing helper used by pipe_adder and its per-stage chunk adder.
package adder_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Bits handled by each pipeline stage.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage : adder_pkg

// File: rtl/adder_chunk.sv
// CW-bit combinational ripple adder slice with carry in/out; one per stage.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_cin,
    output logic [CW-1:0] o_sum_c,
    output logic          o_cout_c
);

    localparam int unsigned SW = CW + 1;

    logic [SW-1:0] w_full;

    assign w_full              = SW'(i_a) + SW'(i_b) + SW'(i_cin);
    assign {o_cout_c, o_sum_c} = w_full;

endmodule : adder_chunk

// File: rtl/pipe_adder.sv
// STAGES-deep carry-pipelined adder/subtractor with valid/ready handshake.
// Define PIPE_ADDER_OVERFLOW_EN to generate the signed overflow flag.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int unsigned CW   = chunk_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Stage registers: index k holds the beat after chunk k has been added.
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_cy    [STAGES];
    mode_e            r_mode  [STAGES];

    // Per-stage inputs (from ports for stage 0, else from previous register).
    logic             w_in_valid [STAGES];
    logic [WIDTH-1:0] w_in_a     [STAGES];
    logic [WIDTH-1:0] w_in_b     [STAGES];
    logic [WIDTH-1:0] w_in_sum   [STAGES];
    logic             w_in_cy    [STAGES];
    mode_e            w_in_mode  [STAGES];

    logic [CW-1:0]    w_b_eff     [STAGES];
    logic [CW-1:0]    w_chunk_sum [STAGES];
    logic             w_chunk_cy  [STAGES];
    logic [WIDTH-1:0] w_nxt_sum   [STAGES];

    logic w_en;

    // Whole pipeline advances together; it only stalls on a blocked output.
    assign w_en    = !r_valid[LAST] || ready_i;
    assign ready_o = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            // Subtract is a + ~b + 1: the +1 rides in on the stage-0 carry.
            assign w_in_valid[k] = valid_i;
            assign w_in_a[k]     = a_i;
            assign w_in_b[k]     = b_i;
            assign w_in_sum[k]   = '0;
            assign w_in_cy[k]    = sub_i ? 1'b1 : carry_i;
            assign w_in_mode[k]  = sub_i ? MODE_SUB : MODE_ADD;
        end else begin : g_body
            assign w_in_valid[k] = r_valid[k-1];
            assign w_in_a[k]     = r_a[k-1];
            assign w_in_b[k]     = r_b[k-1];
            assign w_in_sum[k]   = r_sum[k-1];
            assign w_in_cy[k]    = r_cy[k-1];
            assign w_in_mode[k]  = r_mode[k-1];
        end

        assign w_b_eff[k] = (w_in_mode[k] == MODE_SUB) ? ~w_in_b[k][k*CW +: CW]
                                                       :  w_in_b[k][k*CW +: CW];

        adder_chunk #(
            .CW (CW)
        ) u_chunk (
            .i_a      (w_in_a[k][k*CW +: CW]),
            .i_b      (w_b_eff[k]),
            .i_cin    (w_in_cy[k]),
            .o_sum_c  (w_chunk_sum[k]),
            .o_cout_c (w_chunk_cy[k])
        );

        // Chunks above k are still zero in the partial sum, so OR-in is exact.
        assign w_nxt_sum[k] = w_in_sum[k] | (WIDTH'(w_chunk_sum[k]) << (k * CW));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_cy[k]    <= 1'b0;
                r_mode[k]  <= MODE_ADD;
            end
        end else if (w_en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_in_valid[k];
                r_a[k]     <= w_in_a[k];
                r_b[k]     <= w_in_b[k];
                r_sum[k]   <= w_nxt_sum[k];
                r_cy[k]    <= w_chunk_cy[k];
                r_mode[k]  <= w_in_mode[k];
            end
        end
    end

`ifdef PIPE_ADDER_OVERFLOW_EN
    logic w_ovf_nxt;
    logic r_ovf;

    // Same-sign operands producing an opposite-sign result; formed as the MSB chunk completes.
    assign w_ovf_nxt = (w_in_a[LAST][WIDTH-1] == w_b_eff[LAST][CW-1]) &&
                       (w_nxt_sum[LAST][WIDTH-1] != w_in_a[LAST][WIDTH-1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign overflow_o = r_ovf;
`else
    assign overflow_o = 1'b0;
`endif

    assign valid_o = r_valid[LAST];
    assign sum_o   = r_sum[LAST];
    assign carry_o = r_cy[LAST];

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=4): directed table,
// burst, stall, mid-flight reset and random traffic against a scoreboard.
module tb_pipe_adder;

    localparam int unsigned W   = 32;
    localparam int unsigned STG = 4;
`ifdef PIPE_ADDER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i, ready_o, carry_i, sub_i, valid_o, ready_i;
    logic         carry_o, overflow_o;
    logic [W-1:0] a_i, b_i, sum_o;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cy;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] e_sum;
        logic         e_cy;
        logic         e_ovf;
    } vec_t;

    res_t         q_exp [$];
    res_t         mon_e;
    logic         prev_stall;
    logic [W-1:0] prev_sum;
    logic         prev_cy, prev_ovf;

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (STG)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .carry_i    (carry_i),
        .sub_i      (sub_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .sum_o      (sum_o),
        .carry_o    (carry_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: plain signed/unsigned arithmetic on the whole operands.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t         r;
        longint       sa, sb, st;
        logic [W:0]   u;
        longint       smax, smin;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        sa   = $signed(a);
        sb   = $signed(b);
        if (sub) begin
            st    = sa - sb;
            r.sum = a - b;
            r.cy  = (a >= b);
        end else begin
            st    = sa + sb + longint'(cin);
            u     = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
            r.sum = u[W-1:0];
            r.cy  = u[W];
        end
        r.ovf = OVF_EN && (st > smax || st < smin);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((q_exp.size() != 0 || valid_o) && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk(name, 64'(q_exp.size()), 64'd0);
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_exp.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(valid_o), 64'd1);
                chk("hold_sum", 64'(sum_o), 64'(prev_sum));
                chk("hold_carry", 64'(carry_o), 64'(prev_cy));
                chk("hold_ovf", 64'(overflow_o), 64'(prev_ovf));
            end
            if (valid_o && !ready_i)
                chk("stall_ready", 64'(ready_o), 64'd0);
            if (valid_o && ready_i) begin
                if (q_exp.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL sb_extra: output %h with no beat outstanding", sum_o);
                end else begin
                    mon_e = q_exp.pop_front();
                    chk("sb_sum", 64'(sum_o), 64'(mon_e.sum));
                    chk("sb_carry", 64'(carry_o), 64'(mon_e.cy));
                    chk("sb_ovf", 64'(overflow_o), 64'(mon_e.ovf));
                end
            end
            if (valid_i && ready_o)
                q_exp.push_back(model(a_i, b_i, carry_i, sub_i));
            prev_stall = valid_o && !ready_i;
            prev_sum   = sum_o;
            prev_cy    = carry_o;
            prev_ovf   = overflow_o;
        end
    end

    initial begin
        vec_t vt [8];
        int   lat;
        int   guard;
        logic exp_v;
        logic acc;

        vt[0] = '{a: 32'hFFFF_FFFF, b: 32'h1,         cin: 1'b0, sub: 1'b0, e_sum: 32'h0,         e_cy: 1'b1, e_ovf: 1'b0};
        vt[1] = '{a: 32'h7FFF_FFFF, b: 32'h1,         cin: 1'b0, sub: 1'b0, e_sum: 32'h8000_0000, e_cy: 1'b0, e_ovf: OVF_EN};
        vt[2] = '{a: 32'h5,         b: 32'h7,         cin: 1'b1, sub: 1'b1, e_sum: 32'hFFFF_FFFE, e_cy: 1'b0, e_ovf: 1'b0};
        vt[3] = '{a: 32'h0,         b: 32'h0,         cin: 1'b1, sub: 1'b0, e_sum: 32'h1,         e_cy: 1'b0, e_ovf: 1'b0};
        vt[4] = '{a: 32'h8000_0000, b: 32'h1,         cin: 1'b0, sub: 1'b1, e_sum: 32'h7FFF_FFFF, e_cy: 1'b1, e_ovf: OVF_EN};
        vt[5] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, cin: 1'b1, sub: 1'b0, e_sum: 32'hFFFF_FFFF, e_cy: 1'b1, e_ovf: 1'b0};
        vt[6] = '{a: 32'h0000_FFFF, b: 32'h1,         cin: 1'b0, sub: 1'b0, e_sum: 32'h0001_0000, e_cy: 1'b0, e_ovf: 1'b0};
        vt[7] = '{a: 32'h3,         b: 32'h3,         cin: 1'b0, sub: 1'b1, e_sum: 32'h0,         e_cy: 1'b1, e_ovf: 1'b0};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        a_i     = '0;
        b_i     = '0;
        carry_i = 1'b0;
        sub_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_sum", 64'(sum_o), 64'd0);
        chk("rst_carry", 64'(carry_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 64'(ready_o), 64'd1);

        // Directed single beats: latency and result
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'b1;
            a_i     = vt[i].a;
            b_i     = vt[i].b;
            carry_i = vt[i].cin;
            sub_i   = vt[i].sub;
            @(posedge clk);
            #1 valid_i = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!valid_o && lat < 16);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(STG));
            chk($sformatf("vec%0d_sum", i), 64'(sum_o), 64'(vt[i].e_sum));
            chk($sformatf("vec%0d_carry", i), 64'(carry_o), 64'(vt[i].e_cy));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow_o), 64'(vt[i].e_ovf));
        end

        // Back-to-back burst a=b=i
        @(posedge clk);
        #1;
        for (int c = 0; c < int'(STG) + 10; c++) begin
            if (c < 8) begin
                valid_i = 1'b1;
                a_i     = W'(c + 1);
                b_i     = W'(c + 1);
                carry_i = 1'b0;
                sub_i   = 1'b0;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            exp_v = (c >= int'(STG)) && (c < int'(STG) + 8);
            chk($sformatf("burst_valid_c%0d", c), 64'(valid_o), 64'(exp_v));
            if (exp_v)
                chk($sformatf("burst_sum_c%0d", c), 64'(sum_o), 64'(2 * (c - int'(STG) + 1)));
            @(posedge clk);
            #1;
        end
        drain("burst_drain");

        // Streaming with a 5-cycle downstream stall
        @(posedge clk);
        #1;
        fork
            begin
                for (int n = 0; n < 12; n++) begin
                    valid_i = 1'b1;
                    a_i     = $urandom;
                    b_i     = $urandom;
                    carry_i = 1'($urandom_range(0, 1));
                    sub_i   = 1'($urandom_range(0, 1));
                    guard   = 0;
                    do begin
                        @(negedge clk);
                        acc = ready_o;
                        @(posedge clk);
                        #1;
                        guard++;
                    end while (!acc && guard < 50);
                    if (!acc) chk("stall_accept_timeout", 64'(acc), 64'd1);
                end
                valid_i = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 ready_i = 1'b0;
                @(negedge clk);
                chk("stall_ready_o", 64'(ready_o), 64'd0);
                chk("stall_valid_o", 64'(valid_o), 64'd1);
                repeat (5) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        drain("stall_drain");

        // Reset with three beats in flight
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            valid_i = 1'b1;
            a_i     = (n == 0) ? 32'hFFFF_FFFF : W'(n * 100 + 7);
            b_i     = 32'h1;
            carry_i = 1'b1;
            sub_i   = 1'b0;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("prerst_valid", 64'(valid_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_sum", 64'(sum_o), 64'd0);
        chk("midrst_carry", 64'(carry_o), 64'd0);
        chk("midrst_ovf", 64'(overflow_o), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 64'(ready_o), 64'd1);
        for (int c = 0; c < int'(STG) + 4; c++) begin
            chk($sformatf("postrst_stale_c%0d", c), 64'(valid_o), 64'd0);
            @(negedge clk);
        end

        // Random traffic with random backpressure
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom_range(0, 2) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            a_i     = pick();
            b_i     = pick();
            carry_i = 1'($urandom_range(0, 1));
            sub_i   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain("random_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipe_adder
